// File: rtl/ir_pkg.sv
// Shared constants, FSM state type and parity helper for the IR receive path.
package ir_pkg;

  localparam logic [4:0] SYNC_PATTERN      = 5'b10100;
  localparam int         SYNC_LEN          = 5;
  localparam int         PAYLOAD_LEN       = 4;
  localparam logic [3:0] SAFE_DIRS_DEFAULT = 4'b1111;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_t;

  // Even parity over payload plus parity bit: true when the count of ones is even.
  function automatic logic even_parity_ok(input logic [PAYLOAD_LEN-1:0] d, input logic p);
    return ~(^{d, p});
  endfunction

endpackage

// File: rtl/ir_bit_timer.sv
// Free-running bit timer: tick is high for one Clk cycle out of every BIT_DIV.
module ir_bit_timer #(
  parameter int BIT_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(BIT_DIV - 1);

  logic [7:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/ir_frame_controller.sv
// Frame controller: sync hunt, payload capture, parity check, repeat-confirm
// commit of motor direction bits and a link-silence watchdog.
module ir_frame_controller
  import ir_pkg::*;
#(
  parameter int         BIT_DIV      = 4,
  parameter int         CONFIRM      = 2,
  parameter int         TIMEOUT_BITS = 64,
  parameter logic [3:0] SAFE_DIRS    = SAFE_DIRS_DEFAULT
) (
  input  logic       Clk,
  input  logic       Global_Reset,
  input  logic       Serial_In,
  output logic [3:0] dirs,
  output logic       link_up,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam logic [2:0]  CONFIRM_W = 3'(CONFIRM);
  localparam logic [11:0] TIMEOUT_W = 12'(TIMEOUT_BITS);
  localparam int          CNT_W     = $clog2(PAYLOAD_LEN);

  logic                   tick;
  logic                   sync1_reg, sync2_reg;
  logic                   s_bit;
  state_t                 state_reg, state_next;
  logic [SYNC_LEN-1:0]    hist_reg, hist_next;
  logic [PAYLOAD_LEN-1:0] pay_reg, pay_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [PAYLOAD_LEN-1:0] cand_reg, cand_next;
  logic [2:0]             match_reg, match_next;
  logic [11:0]            wdog_reg, wdog_next;
  logic [3:0]             dirs_reg, dirs_next;
  logic                   link_reg, link_next;
  logic                   valid_reg, valid_next;
  logic                   err_reg, err_next;

  ir_bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
    .clk   (Clk),
    .rst_n (Global_Reset),
    .tick  (tick)
  );

  // The line idles high and is active-low, so invert before synchronizing.
  always_ff @(posedge Clk or negedge Global_Reset) begin
    if (!Global_Reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= ~Serial_In;
      sync2_reg <= sync1_reg;
    end
  end

  assign s_bit = sync2_reg;

  always_ff @(posedge Clk or negedge Global_Reset) begin
    if (!Global_Reset) begin
      state_reg   <= HUNT;
      hist_reg    <= '0;
      pay_reg     <= '0;
      bit_cnt_reg <= '0;
      cand_reg    <= '0;
      match_reg   <= '0;
      wdog_reg    <= '0;
      dirs_reg    <= SAFE_DIRS;
      link_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hist_reg    <= hist_next;
      pay_reg     <= pay_next;
      bit_cnt_reg <= bit_cnt_next;
      cand_reg    <= cand_next;
      match_reg   <= match_next;
      wdog_reg    <= wdog_next;
      dirs_reg    <= dirs_next;
      link_reg    <= link_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    hist_next    = hist_reg;
    pay_next     = pay_reg;
    bit_cnt_next = bit_cnt_reg;
    cand_next    = cand_reg;
    match_next   = match_reg;
    wdog_next    = wdog_reg;
    dirs_next    = dirs_reg;
    link_next    = link_reg;
    valid_next   = 1'b0;
    err_next     = 1'b0;

    if (tick) begin
      if (wdog_reg != TIMEOUT_W) begin
        wdog_next = wdog_reg + 12'd1;
      end

      case (state_reg)
        HUNT: begin
          hist_next = {hist_reg[SYNC_LEN-2:0], s_bit};
          if (hist_next == SYNC_PATTERN) begin
            state_next   = PAYLOAD;
            bit_cnt_next = '0;
          end
        end
        PAYLOAD: begin
          pay_next     = {pay_reg[PAYLOAD_LEN-2:0], s_bit};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == CNT_W'(PAYLOAD_LEN - 1)) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          state_next = HUNT;
          hist_next  = '0;
          if (even_parity_ok(pay_reg, s_bit)) begin
            valid_next = 1'b1;
            wdog_next  = '0;
            cand_next  = pay_reg;
            if (pay_reg == cand_reg) begin
              match_next = (match_reg < CONFIRM_W) ? match_reg + 3'd1 : match_reg;
            end else begin
              match_next = 3'd1;
            end
            if (match_next >= CONFIRM_W) begin
              dirs_next = pay_reg;
              link_next = 1'b1;
            end
          end else begin
            err_next   = 1'b1;
            match_next = '0;
          end
        end
        default: state_next = HUNT;
      endcase

      // A good frame on the expiry tick has already cleared wdog_next.
      if (wdog_reg != TIMEOUT_W && wdog_next == TIMEOUT_W) begin
        dirs_next  = SAFE_DIRS;
        link_next  = 1'b0;
        match_next = '0;
      end
    end
  end

  assign dirs        = dirs_reg;
  assign link_up     = link_reg;
  assign frame_valid = valid_reg;
  assign frame_err   = err_reg;

endmodule

// File: tb/tb_ir_frame_controller.sv
// Directed bench for ir_frame_controller with BIT_DIV=4, CONFIRM=2, TIMEOUT_BITS=64.
module tb_ir_frame_controller;

  logic       Clk = 1'b0;
  logic       Global_Reset = 1'b0;
  logic       Serial_In = 1'b1;
  logic [3:0] dirs;
  logic       link_up;
  logic       frame_valid;
  logic       frame_err;

  ir_frame_controller #(
    .BIT_DIV      (4),
    .CONFIRM      (2),
    .TIMEOUT_BITS (64),
    .SAFE_DIRS    (4'b1111)
  ) dut (
    .Clk          (Clk),
    .Global_Reset (Global_Reset),
    .Serial_In    (Serial_In),
    .dirs         (dirs),
    .link_up      (link_up),
    .frame_valid  (frame_valid),
    .frame_err    (frame_err)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Pulse monitor: one record per frame_valid cycle, plus an error-pulse count.
  int         v_cnt = 0;
  int         e_cnt = 0;
  logic [3:0] v_dirs [64];
  logic       v_link [64];
  int         v_cyc  [64];

  always @(negedge Clk) begin
    if (frame_valid === 1'b1) begin
      if (v_cnt < 64) begin
        v_dirs[v_cnt] = dirs;
        v_link[v_cnt] = link_up;
        v_cyc[v_cnt]  = cyc;
      end
      v_cnt = v_cnt + 1;
    end
    if (frame_err === 1'b1) e_cnt = e_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    Serial_In = ~b;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] pay, input logic p);
    logic [9:0] fr;
    fr = {5'b10100, pay, p};
    $display("frame pay=%b p=%b at cycle %0d", pay, p, cyc);
    for (int i = 9; i >= 0; i--) send_bit(fr[i]);
  endtask

  task automatic idle(input int n);
    Serial_In = 1'b1;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Global_Reset = 1'b0;
    Serial_In    = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Global_Reset = 1'b1;
    idle(2);
  endtask

  int base, eb, n0;
  logic [9:0] part;

  initial begin
    // Reset held with the line toggling
    for (int k = 0; k < 20; k++) begin
      Serial_In = k[0];
      @(posedge Clk);
      #1;
    end
    check("rst_dirs", 32'(dirs), 32'hF);
    check("rst_link", 32'(link_up), 0);
    check("rst_valid", 32'(v_cnt), 0);
    check("rst_err", 32'(e_cnt), 0);
    Global_Reset = 1'b1;
    idle(4);

    // Two good 0101 frames back-to-back
    base = v_cnt; eb = e_cnt;
    send_frame(4'b0101, 1'b0);
    send_frame(4'b0101, 1'b0);
    idle(12);
    check("two_nvalid", 32'(v_cnt - base), 2);
    check("two_nerr", 32'(e_cnt - eb), 0);
    check("two_f1_dirs", 32'(v_dirs[base]), 32'hF);
    check("two_f1_link", 32'(v_link[base]), 0);
    check("two_f2_dirs", 32'(v_dirs[base+1]), 32'h5);
    check("two_f2_link", 32'(v_link[base+1]), 1);
    check("two_dirs", 32'(dirs), 32'h5);

    // Bad parity then two good 0110 frames
    base = v_cnt; eb = e_cnt;
    send_frame(4'b0101, 1'b1);
    send_frame(4'b0110, 1'b0);
    send_frame(4'b0110, 1'b0);
    idle(12);
    check("bad_nerr", 32'(e_cnt - eb), 1);
    check("bad_nvalid", 32'(v_cnt - base), 2);
    check("bad_f1_dirs", 32'(v_dirs[base]), 32'h5);
    check("bad_f2_dirs", 32'(v_dirs[base+1]), 32'h6);
    check("bad_dirs", 32'(dirs), 32'h6);

    // Alternating payloads never confirm
    do_reset();
    base = v_cnt;
    for (int k = 0; k < 6; k++) send_frame(k[0] ? 4'b0110 : 4'b0101, 1'b0);
    idle(12);
    check("alt_nvalid", 32'(v_cnt - base), 6);
    for (int k = 0; k < 6; k++) check($sformatf("alt_dirs%0d", k), 32'(v_dirs[base+k]), 32'hF);
    check("alt_link", 32'(link_up), 0);

    // Timeout after a commit
    do_reset();
    base = v_cnt;
    send_frame(4'b0101, 1'b0);
    send_frame(4'b0101, 1'b0);
    Serial_In = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (v_cnt >= base + 2) break;
      @(posedge Clk);
    end
    check("to_nvalid", 32'(v_cnt - base), 2);
    check("to_commit", 32'(v_dirs[base+1]), 32'h5);
    n0 = v_cyc[base+1];
    for (int k = 0; k < 400; k++) begin
      if (cyc == n0 + 255) break;
      @(negedge Clk);
    end
    check("to_reach", 32'(cyc), 32'(n0 + 255));
    check("to_pre_dirs", 32'(dirs), 32'h5);
    check("to_pre_link", 32'(link_up), 1);
    @(negedge Clk);
    check("to_dirs", 32'(dirs), 32'hF);
    check("to_link", 32'(link_up), 0);

    // Reset mid-frame after a commit
    do_reset();
    send_frame(4'b0101, 1'b0);
    send_frame(4'b0101, 1'b0);
    idle(12);
    check("mid_pre_dirs", 32'(dirs), 32'h5);
    base = v_cnt; eb = e_cnt;
    part = {5'b10100, 4'b0011, 1'b0};
    for (int i = 9; i >= 3; i--) send_bit(part[i]);
    Global_Reset = 1'b0;
    #1;
    check("mid_rst_dirs", 32'(dirs), 32'hF);
    check("mid_rst_link", 32'(link_up), 0);
    repeat (3) @(posedge Clk);
    #1;
    Global_Reset = 1'b1;
    idle(20);
    check("mid_nopulse", 32'((v_cnt - base) + (e_cnt - eb)), 0);
    send_frame(4'b0011, 1'b0);
    send_frame(4'b0011, 1'b0);
    idle(12);
    check("mid_nvalid", 32'(v_cnt - base), 2);
    check("mid_dirs", 32'(dirs), 32'h3);
    check("mid_link", 32'(link_up), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
